// File: rtl/imem_boot_pkg.sv
// imem_boot_pkg: shared states and instruction-memory geometry for the boot loader
package imem_boot_pkg;
  localparam int IMEM_ADDR_W = 8;
  localparam int IMEM_DEPTH  = 256;
  typedef enum logic [2:0] {IDLE, LOAD, DRAIN, RUN, FAULT} state_t;
endpackage

// File: rtl/imem_boot_cksum.sv
// imem_boot_cksum: wrap-around sum of accepted words compared against an expected value
module imem_boot_cksum (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        add,
  input  logic [31:0] data,
  input  logic [31:0] exp_sum,
  output logic        match
);
  logic [31:0] sum;
  logic [31:0] ref_q;
  // clear and latch the expected sum on an accepted start, accumulate on each handshake
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sum   <= '0;
      ref_q <= '0;
    end else if (clr) begin
      sum   <= '0;
      ref_q <= exp_sum;
    end else if (add) begin
      sum <= sum + data;
    end
  assign match = sum == ref_q;
endmodule

// File: rtl/imem_boot_ctrl.sv
// imem_boot_ctrl: streams a program into imem and holds the core in reset until loaded (checksum option: IMEM_BOOT_CHECKSUM_EN)
module imem_boot_ctrl
  import imem_boot_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DEPTH  = IMEM_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic              s_valid,
  input  logic [31:0]       s_data,
`ifdef IMEM_BOOT_CHECKSUM_EN
  input  logic [31:0]       exp_sum,
`endif
  output logic              s_ready,
  output logic              im_en,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_data,
  output logic              core_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err
);
  state_t          state, next;
  logic [ADDR_W:0] cnt, len, cnt_nx;
  logic            hs, last, legal, can_start, go, nogo, cks_ok;
  assign legal      = (word_count != '0) && (word_count <= (ADDR_W+1)'(DEPTH));
  assign can_start  = state inside {IDLE, RUN, FAULT};
  assign go         = start & can_start & legal;
  assign nogo       = start & can_start & ~legal;
  assign s_ready    = state == LOAD;
  assign busy       = (state == LOAD) | (state == DRAIN);
  assign core_rst_n = state == RUN;
  assign hs         = s_valid & s_ready;
  assign cnt_nx     = cnt + 1'b1;
  assign last       = hs & (cnt_nx == len);
`ifdef IMEM_BOOT_CHECKSUM_EN
  imem_boot_cksum u_cksum (
    .clk     (clk),
    .rst     (rst),
    .clr     (go),
    .add     (hs),
    .data    (s_data),
    .exp_sum (exp_sum),
    .match   (cks_ok)
  );
`else
  assign cks_ok = 1'b1;
`endif
  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= next;
  // next state: start is honoured only outside LOAD/DRAIN, DRAIN lasts exactly one cycle
  always_comb begin
    next = state;
    case (state)
      IDLE, RUN, FAULT: next = start ? (legal ? LOAD : FAULT) : state;
      LOAD:             next = last ? DRAIN : LOAD;
      DRAIN:            next = cks_ok ? RUN : FAULT;
      default:          next = IDLE;
    endcase
  end
  // write port is registered so the write lands one cycle after its handshake
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt     <= '0;
      len     <= '0;
      im_en   <= 1'b0;
      im_addr <= '0;
      im_data <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      im_en <= hs;
      done  <= (state == DRAIN) & cks_ok;
      if (hs) begin
        im_addr <= cnt[ADDR_W-1:0];
        im_data <= s_data;
        cnt     <= cnt_nx;
      end
      if (go) begin
        len <= word_count;
        cnt <= '0;
        err <= 1'b0;
      end
      if (nogo || (state == DRAIN && !cks_ok)) err <= 1'b1;
    end
endmodule

// File: tb/tb_imem_boot_ctrl.sv
// tb_imem_boot_ctrl: randomized load scenarios checked against a words-remaining reference model
module tb_imem_boot_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [8:0]  word_count;
  logic        s_valid;
  logic [31:0] s_data;
  logic [31:0] exp_sum;
  logic        s_ready, im_en, core_rst_n, busy, done, err;
  logic [7:0]  im_addr;
  logic [31:0] im_data;
  logic [31:0] words [256];
  int          total = 0;
  int          bad = 0;

  imem_boot_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .word_count (word_count),
    .s_valid    (s_valid),
    .s_data     (s_data),
`ifdef IMEM_BOOT_CHECKSUM_EN
    .exp_sum    (exp_sum),
`endif
    .s_ready    (s_ready),
    .im_en      (im_en),
    .im_addr    (im_addr),
    .im_data    (im_data),
    .core_rst_n (core_rst_n),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic check_reset_vals(string tag);
    check({tag, ".s_ready"}, s_ready, 0);
    check({tag, ".im_en"}, im_en, 0);
    check({tag, ".im_addr"}, im_addr, 0);
    check({tag, ".im_data"}, im_data, 0);
    check({tag, ".core_rst_n"}, core_rst_n, 0);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".done"}, done, 0);
    check({tag, ".err"}, err, 0);
  endtask

  // called at a negedge; model tracks words left, the pending write and cycles since the final handshake
  task automatic run_load(int n, int vmode, int abort_at, bit bad_sum);
    bit          pat [6] = '{1, 0, 0, 1, 0, 1};
    int          idx = 0, left = n, post = 0, prev_idx = 0, cyc = 0, wr = 0;
    bit          prev_hs = 0, hs, ok = 1;
    logic [31:0] sum = 0;
    for (int i = 0; i < n; i++) sum += words[i];
    exp_sum = bad_sum ? sum + 1 : sum;
`ifdef IMEM_BOOT_CHECKSUM_EN
    ok = !bad_sum;
`endif
    start = 1'b1;
    word_count = n[8:0];
    s_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    while (post < 4 && cyc < n * 20 + 50) begin
      check("ready", s_ready, left > 0);
      check("busy", busy, left > 0 || post == 1);
      check("core_rst_n", core_rst_n, post >= 2 && ok);
      check("done", done, post == 2 && ok);
      check("err", err, post >= 2 && !ok);
      check("im_en", im_en, prev_hs);
      if (prev_hs) begin
        check("im_addr", im_addr, prev_idx);
        check("im_data", im_data, words[prev_idx]);
      end
      wr += int'(im_en);
      if (abort_at > 0 && idx == abort_at) begin
        #2 rst = 1'b0;
        #1 check_reset_vals("abort");
        @(negedge clk);
        rst = 1'b1;
        s_valid = 1'b1;
        repeat (4) begin
          @(negedge clk);
          check("post_abort.im_en", im_en, 0);
          check("post_abort.s_ready", s_ready, 0);
          check("post_abort.core_rst_n", core_rst_n, 0);
        end
        s_valid = 1'b0;
        return;
      end
      s_valid = vmode == 0 ? 1'b1 : vmode == 1 ? (cyc < 6 ? pat[cyc] : 1'b1) : ($urandom % 4 != 0);
      s_data = idx < n ? words[idx] : $urandom;
      hs = s_valid && left > 0;
      @(negedge clk);
      cyc++;
      prev_hs = hs;
      prev_idx = idx;
      if (post > 0) post++;
      if (hs) begin
        idx++;
        left--;
        if (left == 0) post = 1;
      end
    end
    s_valid = 1'b0;
    check("timeout", post >= 4, 1);
    check("writes", wr, n);
  endtask

  task automatic bad_start(int wc);
    start = 1'b1;
    word_count = wc[8:0];
    @(negedge clk);
    start = 1'b0;
    s_valid = 1'b1;
    repeat (3) begin
      check("bad.err", err, 1);
      check("bad.s_ready", s_ready, 0);
      check("bad.im_en", im_en, 0);
      check("bad.core_rst_n", core_rst_n, 0);
      check("bad.busy", busy, 0);
      check("bad.done", done, 0);
      @(negedge clk);
    end
    s_valid = 1'b0;
  endtask

  task automatic rand_words(int n);
    for (int i = 0; i < n; i++) words[i] = $urandom;
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    word_count = '0;
    s_valid = 1'b0;
    s_data = '0;
    exp_sum = '0;
    #1 check_reset_vals("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("idle.core_rst_n", core_rst_n, 0);
    check("idle.s_ready", s_ready, 0);
    words[0] = 32'h00500093;
    words[1] = 32'h00100113;
    words[2] = 32'h002081B3;
    words[3] = 32'h0000006F;
    run_load(4, 0, 0, 0);
    rand_words(3);
    run_load(3, 1, 0, 0);
    bad_start(0);
    bad_start(257);
    bad_start($urandom_range(258, 511));
    rand_words(1);
    run_load(1, 0, 0, 0);
    for (int i = 0; i < 256; i++) words[i] = i;
    run_load(256, 2, 0, 0);
    rand_words(2);
    run_load(2, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      int n = $urandom_range(1, 20);
      rand_words(n);
      run_load(n, 2, 0, 0);
    end
    rand_words(5);
    run_load(5, 0, 2, 0);
    rand_words(3);
    run_load(3, 2, 0, 0);
`ifdef IMEM_BOOT_CHECKSUM_EN
    words[0] = 32'hFFFFFFFF;
    words[1] = 32'h00000002;
    run_load(2, 0, 0, 0);
    run_load(2, 0, 0, 1);
    rand_words(4);
    run_load(4, 2, 0, 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
